branch_predictor: RTL

// - IF-stage 2-bit saturating-counter branch predictor. Consumer of the EX-stage branch feedback (feedback_valid, prediction_incorrect, jump_noblock).
// - Supplies branch_taken_in to the ID/EX path.
// - Tracks in-flight predictions in order in a pending FIFO. Resolves each EX feedback pulse against the oldest entry and trains the pattern table.

---
 rtl/bp_pkg.sv | 46 ++++
 rtl/branch_predictor_if.sv | 35 +++
 rtl/bp_pend_fifo.sv | 82 ++++++++
 rtl/branch_predictor.sv | 104 ++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module : bp_pkg
// Desc   : Shared types, encodings and helpers for the branch predictor.
// Rev    : 1.0  initial release
// ============================================================================
package bp_pkg;

  localparam int BP_BIT_W      = 32;
  localparam int BP_IDX_W      = 4;
  localparam int BP_PEND_DEPTH = 4;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  // Pending-entry layout at the default index width.
  typedef struct packed {
    logic [BP_IDX_W-1:0] idx;
    logic                pred;
  } pend_entry_t;

  function automatic ctr_t ctr_train(input ctr_t cur, input logic taken);
    ctr_t nxt;
    nxt = cur;
    if (taken) begin
      case (cur)
        SNT:     nxt = WNT;
        WNT:     nxt = WT;
        default: nxt = ST;
      endcase
    end else begin
      case (cur)
        ST:      nxt = WT;
        WT:      nxt = WNT;
        default: nxt = SNT;
      endcase
    end
    return nxt;
  endfunction

endpackage : bp_pkg
`default_nettype wire

// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
// Module : branch_predictor_if
// Desc   : IF-stage request/prediction and EX-stage feedback bundle.
// Rev    : 1.0  initial release
// ============================================================================
interface branch_predictor_if #(
  parameter int BIT_W      = 32,
  parameter int PEND_DEPTH = 4
);

  logic                            stall;
  logic                            if_branch;
  logic [BIT_W-1:0]                if_pc;
  logic                            predict_taken;
  logic                            bp_ready;
  logic                            feedback_valid;
  logic                            prediction_incorrect;
  logic                            jump_noblock;
  logic [$clog2(PEND_DEPTH):0]     pend_count;
  logic                            overflow_err;
  logic                            underflow_err;

  modport master (
    output stall, if_branch, if_pc, feedback_valid, prediction_incorrect, jump_noblock,
    input  predict_taken, bp_ready, pend_count, overflow_err, underflow_err
  );

  modport slave (
    input  stall, if_branch, if_pc, feedback_valid, prediction_incorrect, jump_noblock,
    output predict_taken, bp_ready, pend_count, overflow_err, underflow_err
  );

endinterface : branch_predictor_if
`default_nettype wire

// File: rtl/bp_pend_fifo.sv
`default_nettype none
// ============================================================================
// Module : bp_pend_fifo
// Desc   : In-order FIFO of in-flight predictions with synchronous clear.
// Rev    : 1.0  initial release
// ============================================================================
module bp_pend_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 5
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       push,
  input  wire logic [DATA_W-1:0]          push_data,
  input  wire logic                       pop,
  input  wire logic                       clear,
  output logic      [DATA_W-1:0]          pop_data,
  output logic                            full,
  output logic                            empty,
  output logic      [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              do_push, do_pop;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule : bp_pend_fifo
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module : branch_predictor
// Desc   : IF-stage 2-bit saturating-counter predictor with in-order feedback.
// Rev    : 1.0  initial release
// ============================================================================
module branch_predictor
  import bp_pkg::*;
#(
  parameter int BIT_W      = BP_BIT_W,
  parameter int IDX_W      = BP_IDX_W,
  parameter int PEND_DEPTH = BP_PEND_DEPTH
) (
  input  wire logic          clk,
  input  wire logic          rst,
  branch_predictor_if.slave  bp
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int ENTRY_W = IDX_W + 1;

  ctr_t ctr_q [ENTRIES];
  ctr_t ctr_d [ENTRIES];
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  logic [IDX_W-1:0]          if_idx;
  logic                      pred;
  logic                      push_req, pop_req, flush;
  logic                      fifo_push;
  logic                      fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]        head;
  logic [IDX_W-1:0]          head_idx;
  logic                      head_pred;
  logic                      actual_taken;
  logic [$clog2(PEND_DEPTH):0] fifo_count;
  logic                      unused_pc;

  // Halfword-aligned index keeps compressed instructions distinct.
  assign if_idx    = bp.if_pc[IDX_W:1];
  assign unused_pc = ^{bp.if_pc[BIT_W-1:IDX_W+1], bp.if_pc[0]};
  assign pred      = ctr_q[if_idx][1];

  assign push_req = bp.if_branch & ~bp.stall;
  assign pop_req  = bp.feedback_valid & ~bp.stall;
  assign flush    = ~bp.stall & ((bp.feedback_valid & bp.prediction_incorrect) | bp.jump_noblock);
  // Anything enqueued alongside a flush is on the wrong path.
  assign fifo_push = push_req & ~flush;

  assign head_idx     = head[ENTRY_W-1:1];
  assign head_pred    = head[0];
  assign actual_taken = head_pred ^ bp.prediction_incorrect;

  bp_pend_fifo #(
    .DEPTH  (PEND_DEPTH),
    .DATA_W (ENTRY_W)
  ) u_pend_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({if_idx, pred}),
    .pop       (pop_req),
    .clear     (flush),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    ctr_d       = ctr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (pop_req & ~fifo_empty) begin
      ctr_d[head_idx] = ctr_train(ctr_q[head_idx], actual_taken);
    end
    if (pop_req & fifo_empty) begin
      underflow_d = 1'b1;
    end
    if (push_req & fifo_full & ~pop_req) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WNT;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      ctr_q       <= ctr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bp.predict_taken = pred;
  assign bp.bp_ready      = ~fifo_full | pop_req;
  assign bp.pend_count    = fifo_count;
  assign bp.overflow_err  = overflow_q;
  assign bp.underflow_err = underflow_q;

endmodule : branch_predictor
`default_nettype wire
